inst_fetch_buf: RTL

Instruction prefetch buffer between the PC stage and the IF/ID boundary. It takes the fetch address offered each cycle by the PC stage and issues it to instruction memory over a request/grant bus. It pairs in-order memory responses with their PCs and queues them in a small FIFO for decode. On a taken branch it flushes queued and in-flight fetches, and it back-pressures the PC stage through a stall request.

---
 rtl/inst_fetch_buf.sv | 106 ++++++++++
 1 files changed

// File: rtl/inst_fetch_buf.sv
// Instruction prefetch buffer: issues PC-stage fetches over a req/gnt bus, pairs
// in-order responses with their PCs in a small FIFO, and flushes on taken branches.
module inst_fetch_buf #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        pc_ce_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    input  logic        id_ready_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [31:0]   addr_mem [2**AW];
    logic [AW-1:0] addr_rd_ptr;
    logic [AW-1:0] addr_wr_ptr;
    logic [OW-1:0] out_cnt;
    logic [OW-1:0] disc_cnt;

    logic [SW-1:0] occupancy;
    logic          fifo_valid;
    logic          credit_ok;
    logic          issue;
    logic          resp;
    logic          drop;
    logic          push;
    logic          pop;

    // A same-cycle pop frees a slot immediately, so a full buffer can issue
    // again in the very cycle decode consumes an entry.
    always_comb begin
        fifo_valid  = (count != '0);
        pop         = fifo_valid & id_ready_i & ~flush_i;
        occupancy   = SW'(count) - SW'(pop) + SW'(out_cnt - disc_cnt);
        credit_ok   = (occupancy < SW'(DEPTH)) && (out_cnt < OW'(MAX_OUT));
        imem_req_o  = pc_ce_i & ~flush_i & credit_ok & ~rst;
        issue       = imem_req_o & imem_gnt_i;
        stall_req_o = pc_ce_i & ~flush_i & ~issue & ~rst;
        resp        = imem_rvalid_i & (out_cnt != '0);
        drop        = resp & (disc_cnt != '0);
        push        = resp & ~drop & ~flush_i;
    end

    assign imem_addr_o = pc_i;
    assign id_valid_o  = fifo_valid;
    assign id_pc_o     = fifo_valid ? pc_mem[rd_ptr]   : '0;
    assign id_inst_o   = fifo_valid ? inst_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            addr_rd_ptr <= '0;
            addr_wr_ptr <= '0;
            out_cnt     <= '0;
            disc_cnt    <= '0;
        end else begin
            if (issue) addr_wr_ptr <= addr_wr_ptr + 1'b1;
            if (resp)  addr_rd_ptr <= addr_rd_ptr + 1'b1;
            out_cnt <= out_cnt + OW'(issue) - OW'(resp);
            // Every request still in flight after a flush belongs to the old path.
            if (flush_i) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                disc_cnt <= out_cnt - OW'(resp);
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count    <= count + CW'(push) - CW'(pop);
                disc_cnt <= disc_cnt - OW'(drop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) addr_mem[addr_wr_ptr] <= pc_i;
        if (push) begin
            pc_mem[wr_ptr]   <= addr_mem[addr_rd_ptr];
            inst_mem[wr_ptr] <= imem_rdata_i;
        end
    end

endmodule
